// File: rtl/chimp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chimp_pkg
// Brief    : Shared state encoding, cell field offsets and level clamp helper
//            for the chimp board controller.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package chimp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLACE = 3'd2,
        S_PLAY  = 3'd3,
        S_WIN   = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    // Cell layout is {active, shown, num}; num sits at the bottom.
    localparam int NUM_LSB = 0;

    function automatic int shown_bit(input int num_w);
        return NUM_LSB + num_w;
    endfunction

    function automatic int active_bit(input int num_w);
        return NUM_LSB + num_w + 1;
    endfunction

    function automatic int max_level(input int ncells, input int num_w);
        int lim;
        lim = (1 << num_w) - 1;
        return (ncells < lim) ? ncells : lim;
    endfunction

    function automatic int clamp_level(input int level, input int max_lvl);
        if (level == 0)
            return 1;
        else if (level > max_lvl)
            return max_lvl;
        else
            return level;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chimp_board_ctrl_place.sv
`default_nettype none
// ============================================================================
// Module   : chimp_place_unit
// Brief    : Accept/reject of one placement candidate taken from the random
//            word, against the current active-bit vector.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module chimp_place_unit
    import chimp_pkg::*;
#(
    parameter int NCELLS = 9,
    parameter int IDX_W  = 4,
    parameter int RAND_W = 8
) (
    input  logic [RAND_W-1:0] randNum,
    input  logic [NCELLS-1:0] active,
    output logic [IDX_W-1:0]  cand,
    output logic              accept
);

    logic w_in_range;
    logic w_taken;

    assign cand = randNum[IDX_W-1:0];

    generate
        if (RAND_W > IDX_W) begin : g_rand_spare
            logic w_unused_rand;
            assign w_unused_rand = ^randNum[RAND_W-1:IDX_W];
        end
    endgenerate

    // Matching against each real cell doubles as the cand<NCELLS range check.
    always_comb begin
        w_in_range = 1'b0;
        w_taken    = 1'b0;
        for (int i = 0; i < NCELLS; i++) begin
            if (cand == i[IDX_W-1:0]) begin
                w_in_range = 1'b1;
                w_taken    = active[i];
            end
        end
    end

    assign accept = w_in_range & ~w_taken;

endmodule
`default_nettype wire

// File: rtl/chimp_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chimp_board_ctrl
// Brief    : ROWS x COLS chimp memory-game board: random placement of 1..level,
//            ordered pick scoring. Define CHIMP_STRIKES_EN for strike counting.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module chimp_board_ctrl
    import chimp_pkg::*;
#(
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int NUM_W       = 5,
    parameter int RAND_W      = 8,
    parameter int MAX_STRIKES = 3,
    localparam int NCELLS     = ROWS * COLS,
    localparam int IDX_W      = $clog2(NCELLS),
    localparam int CELL_W     = NUM_W + 2
) (
    input  logic                     clk,
    input  logic                     iKey0,
    input  logic                     start,
    input  logic [NUM_W-1:0]         level,
    input  logic [RAND_W-1:0]        randNum,
    input  logic                     pick_valid,
    input  logic [IDX_W-1:0]         pick_idx,
    output logic [NCELLS*CELL_W-1:0] board,
    output logic                     busy,
    output logic                     playing,
    output logic                     win,
    output logic                     fail,
    output logic [NUM_W-1:0]         expected,
    output logic [1:0]               strikes
);

    localparam int             MAX_LVL    = max_level(NCELLS, NUM_W);
    localparam int             SHOWN_BIT  = shown_bit(NUM_W);
    localparam int             ACTIVE_BIT = active_bit(NUM_W);
    localparam logic [NUM_W-1:0] c_one    = NUM_W'(1);

    state_t            r_state;
    logic [NUM_W-1:0]  r_num [NCELLS];
    logic [NCELLS-1:0] r_active;
    logic [NCELLS-1:0] r_shown;
    logic [NUM_W-1:0]  r_lvl;
    logic [NUM_W-1:0]  r_placed;
    logic [NUM_W-1:0]  r_expected;

    logic [IDX_W-1:0]  w_cand;
    logic              w_accept;
    logic [NUM_W-1:0]  w_placed_nxt;
    logic [NUM_W-1:0]  w_lvl_clamped;
    logic              w_pick_hit;
    logic [NUM_W-1:0]  w_pick_num;

    chimp_place_unit #(
        .NCELLS (NCELLS),
        .IDX_W  (IDX_W),
        .RAND_W (RAND_W)
    ) u_place (
        .randNum (randNum),
        .active  (r_active),
        .cand    (w_cand),
        .accept  (w_accept)
    );

    assign w_placed_nxt  = r_placed + c_one;
    assign w_lvl_clamped = NUM_W'(clamp_level(int'(level), MAX_LVL));

    // Picks outside the grid never match a cell and so read as inactive.
    always_comb begin
        w_pick_hit = 1'b0;
        w_pick_num = '0;
        for (int i = 0; i < NCELLS; i++) begin
            if (pick_idx == i[IDX_W-1:0]) begin
                w_pick_hit = r_active[i];
                w_pick_num = r_num[i];
            end
        end
    end

`ifdef CHIMP_STRIKES_EN
    localparam logic [1:0] c_max_strikes = 2'(MAX_STRIKES);
    logic [1:0] r_strikes;
    logic [1:0] w_strikes_nxt;
    assign w_strikes_nxt = r_strikes + 2'd1;
    assign strikes       = r_strikes;
`else
    assign strikes = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (iKey0) begin
            r_state    <= S_IDLE;
            r_active   <= '0;
            r_shown    <= '0;
            r_lvl      <= c_one;
            r_placed   <= '0;
            r_expected <= c_one;
            for (int i = 0; i < NCELLS; i++)
                r_num[i] <= '0;
`ifdef CHIMP_STRIKES_EN
            r_strikes  <= 2'd0;
`endif
        end else if (start) begin
            r_lvl   <= w_lvl_clamped;
            r_state <= S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_active   <= '0;
                    r_shown    <= '0;
                    r_placed   <= '0;
                    r_expected <= c_one;
                    for (int i = 0; i < NCELLS; i++)
                        r_num[i] <= '0;
`ifdef CHIMP_STRIKES_EN
                    r_strikes  <= 2'd0;
`endif
                    r_state    <= S_PLACE;
                end
                S_PLACE: begin
                    if (w_accept) begin
                        for (int i = 0; i < NCELLS; i++) begin
                            if (w_cand == i[IDX_W-1:0]) begin
                                r_num[i]    <= w_placed_nxt;
                                r_active[i] <= 1'b1;
                                r_shown[i]  <= 1'b1;
                            end
                        end
                        r_placed <= w_placed_nxt;
                        if (w_placed_nxt == r_lvl)
                            r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (pick_valid && w_pick_hit) begin
                        if (w_pick_num == r_expected) begin
                            r_shown <= '0;
                            for (int i = 0; i < NCELLS; i++) begin
                                if (pick_idx == i[IDX_W-1:0])
                                    r_active[i] <= 1'b0;
                            end
                            if (r_expected == r_lvl)
                                r_state <= S_WIN;
                            else
                                r_expected <= r_expected + c_one;
                        end else begin
`ifdef CHIMP_STRIKES_EN
                            r_strikes <= w_strikes_nxt;
                            if (w_strikes_nxt == c_max_strikes)
                                r_state <= S_FAIL;
`else
                            r_state <= S_FAIL;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == S_CLEAR) || (r_state == S_PLACE);
    assign playing  = (r_state == S_PLAY);
    assign win      = (r_state == S_WIN);
    assign fail     = (r_state == S_FAIL);
    assign expected = r_expected;

    generate
        for (genvar gi = 0; gi < NCELLS; gi++) begin : g_board
            assign board[gi*CELL_W + ACTIVE_BIT]          = r_active[gi];
            assign board[gi*CELL_W + SHOWN_BIT]           = r_shown[gi];
            assign board[gi*CELL_W + NUM_LSB +: NUM_W]    = r_num[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chimp_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chimp_board_ctrl
// Brief    : Randomised self-checking bench for chimp_board_ctrl (3x3 board)
//            against a round-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chimp_board_ctrl;

    localparam int NC = 9;
    localparam int MS = 3;
    localparam int M_IDLE = 0, M_BUSY = 1, M_PLAY = 2, M_WIN = 3, M_FAIL = 4;

    logic        clk = 1'b0;
    logic        iKey0, start, pick_valid;
    logic [4:0]  level;
    logic [7:0]  randNum;
    logic [3:0]  pick_idx;
    logic [62:0] board;
    logic        busy, playing, win, fail;
    logic [4:0]  expected;
    logic [1:0]  strikes;

    always #5 clk = ~clk;

    chimp_board_ctrl #(
        .ROWS(3), .COLS(3), .NUM_W(5), .RAND_W(8), .MAX_STRIKES(MS)
    ) dut (
        .clk(clk), .iKey0(iKey0), .start(start), .level(level),
        .randNum(randNum), .pick_valid(pick_valid), .pick_idx(pick_idx),
        .board(board), .busy(busy), .playing(playing), .win(win),
        .fail(fail), .expected(expected), .strikes(strikes)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of one board
    int m_num [NC];
    bit m_act [NC];
    bit m_shw [NC];
    int m_exp, m_lvl, m_placed, m_strk, m_st;
    int rq[$];
    int sp_pick = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [62:0] m_board();
        logic [62:0] b;
        b = '0;
        for (int i = 0; i < NC; i++)
            b[i*7 +: 7] = {m_act[i], m_shw[i], 5'(m_num[i])};
        return b;
    endfunction

    function automatic int find_cell(input int n);
        for (int i = 0; i < NC; i++)
            if (m_act[i] && m_num[i] == n) return i;
        return -1;
    endfunction

    function automatic void m_wipe();
        for (int i = 0; i < NC; i++) begin
            m_num[i] = 0; m_act[i] = 0; m_shw[i] = 0;
        end
        m_exp = 1; m_strk = 0; m_placed = 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_board"},   {1'b0, board}, {1'b0, m_board()});
        check({tag, "_expected"}, 64'(expected), 64'(m_exp));
        check({tag, "_strikes"},  64'(strikes),  64'(m_strk));
        check({tag, "_busy"},     64'(busy),     64'(m_st == M_BUSY));
        check({tag, "_playing"},  64'(playing),  64'(m_st == M_PLAY));
        check({tag, "_win"},      64'(win),      64'(m_st == M_WIN));
        check({tag, "_fail"},     64'(fail),     64'(m_st == M_FAIL));
    endtask

    task automatic do_reset();
        iKey0 = 1'b1;
        tick();
        iKey0 = 1'b0;
        m_wipe();
        m_st = M_IDLE;
        check_all("reset");
    endtask

    // Start a round, run CLEAR and PLACE; returns PLACE cycle count.
    task automatic start_round(input int lv, input bit noisy, output int cyc);
        int v, c;
        start = 1'b1;
        level = 5'(lv);
        pick_valid = (sp_pick >= 0);
        pick_idx   = 4'(sp_pick < 0 ? 0 : sp_pick);
        tick();
        start = 1'b0;
        pick_valid = 1'b0;
        sp_pick = -1;
        m_st = M_BUSY;
        check_all("start");
        tick();
        m_wipe();
        m_lvl = (lv == 0) ? 1 : ((lv > NC) ? NC : lv);
        check_all("clear");
        cyc = 0;
        while (1) begin
            v = (rq.size() > 0) ? rq.pop_front() : int'($urandom_range(0, 255));
            randNum    = 8'(v);
            pick_valid = noisy && ($urandom_range(0, 1) == 1);
            pick_idx   = 4'($urandom_range(0, 15));
            tick();
            pick_valid = 1'b0;
            cyc++;
            c = v & 15;
            if (c < NC && !m_act[c]) begin
                m_placed++;
                m_num[c] = m_placed;
                m_act[c] = 1;
                m_shw[c] = 1;
            end
            check("place_playing", 64'(playing), 64'(m_placed == m_lvl));
            if (playing || m_placed == m_lvl) break;
            if (cyc >= 400) begin
                check("place_timeout", 64'(cyc), 64'(0));
                break;
            end
        end
        m_st = M_PLAY;
        check_all("placed");
    endtask

    task automatic pick(input int idx);
        pick_valid = 1'b1;
        pick_idx   = 4'(idx);
        tick();
        pick_valid = 1'b0;
        if (m_st == M_PLAY && idx < NC && m_act[idx]) begin
            if (m_num[idx] == m_exp) begin
                m_act[idx] = 0;
                for (int i = 0; i < NC; i++) m_shw[i] = 0;
                if (m_exp == m_lvl) m_st = M_WIN;
                else m_exp++;
            end else begin
`ifdef CHIMP_STRIKES_EN
                m_strk++;
                if (m_strk == MS) m_st = M_FAIL;
`else
                m_st = M_FAIL;
`endif
            end
        end
        check_all("pick");
    endtask

    initial begin
        int cyc, k, mask;
        iKey0 = 1'b1; start = 1'b0; level = '0; randNum = '0;
        pick_valid = 1'b0; pick_idx = '0;
        tick(); tick();
        do_reset();

        // Directed placement: rejects on repeated 2, on 9 and on 15
        rq = '{2, 2, 9, 15, 0, 7, 4};
        start_round(4, 1'b0, cyc);
        check("place_cycles", 64'(cyc), 64'd7);
        check("cell2", 64'(board[2*7 +: 7]), 64'h61);
        check("cell0", 64'(board[0*7 +: 7]), 64'h62);
        check("cell7", 64'(board[7*7 +: 7]), 64'h63);
        check("cell4", 64'(board[4*7 +: 7]), 64'h64);
        pick(2);
        check("first_pick_exp", 64'(expected), 64'd2);
        pick(0); pick(7); pick(4);
        check("win_flag", 64'(win), 64'd1);
        pick(2);

        // Same board, wrong second pick
        rq = '{2, 2, 9, 15, 0, 7, 4};
        start_round(4, 1'b0, cyc);
        pick(2);
        pick(4);
`ifdef CHIMP_STRIKES_EN
        check("strike1", 64'(strikes), 64'd1);
        check("strike1_play", 64'(playing), 64'd1);
        pick(4); pick(4);
`endif
        check("fail_flag", 64'(fail), 64'd1);
        pick(0);

        // Reset in the middle of PLACE after two placements
        start = 1'b1; level = 5'd5; tick(); start = 1'b0;
        tick();
        randNum = 8'd1; tick();
        randNum = 8'd3; tick();
        iKey0 = 1'b1; tick(); iKey0 = 1'b0;
        m_wipe();
        m_st = M_IDLE;
        check_all("midplace_reset");

        // Level 0 becomes 1; empty-cell and out-of-range picks ignored
        start_round(0, 1'b1, cyc);
        for (int i = 0; i < NC; i++)
            if (!m_act[i]) begin k = i; break; end
        pick(k);
        pick(12);
        pick(15);
        pick(find_cell(1));
        check("lvl0_win", 64'(win), 64'd1);

        // Level 31 clamps to a full permutation of 1..9
        start_round(31, 1'b1, cyc);
        mask = 0;
        for (int i = 0; i < NC; i++) begin
            k = int'(board[i*7 +: 5]);
            if (board[i*7 + 6] && k >= 1 && k <= NC) mask |= (1 << (k - 1));
        end
        check("perm_mask", 64'(mask), 64'h1FF);
        pick(find_cell(1));
        k = find_cell(1 + 1);
        pick(k - (k > 0 ? 1 : -1) >= 0 ? find_cell(2) : 0);
        // start together with a valid pick: the pick must be discarded
        sp_pick = find_cell(m_exp);
        start_round(3, 1'b0, cyc);

        // Randomised rounds
        for (int r = 0; r < 10; r++) begin
            start_round(int'($urandom_range(0, 31)), 1'b1, cyc);
            for (int p = 0; p < 14 && m_st == M_PLAY; p++) begin
                if ($urandom_range(0, 3) != 0) pick(find_cell(m_exp));
                else pick(int'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
